// File: rtl/pong_pkg.sv
// Purpose: shared pong geometry, paddle position types and a clamp helper.
// Latency: n/a (constants, types and a combinational function only).
// Backpressure: n/a.
package pong_pkg;

    localparam int SCREEN_W        = 640;
    localparam int SCREEN_H        = 480;
    localparam int BALL_SIZE       = 10;
    localparam int PADDLE_W        = 10;
    localparam int PADDLE_H        = 60;
    localparam int PADDLEL_X       = 20;
    localparam int PADDLER_X       = SCREEN_W - 20 - PADDLE_W;
    localparam int PADDLE_Y_MAX    = SCREEN_H - PADDLE_H;
    localparam int PADDLE_Y_CENTER = PADDLE_Y_MAX / 2;

    // Screen coordinate as carried on ports, and the wider signed form used
    // for arithmetic so that under/overflow is visible before clamping.
    typedef logic [9:0]         ypos_t;
    typedef logic signed [11:0] ycalc_t;

    // Saturate a signed candidate position into [0, PADDLE_Y_MAX].
    function automatic ypos_t clamp_y(input ycalc_t v);
        ypos_t r;
        if (v < 12'sd0) begin
            r = '0;
        end else if (v > ycalc_t'(PADDLE_Y_MAX)) begin
            r = ypos_t'(PADDLE_Y_MAX);
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/paddle_control_if.sv
// Purpose: bundles player/game inputs and paddle positions for paddle_control.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels sampled every cycle.
interface paddle_control_if;
    import pong_pkg::*;

    logic  btnL_up;
    logic  btnL_dn;
    logic  btnR_up;
    logic  btnR_dn;
    logic  ai_mode;
    logic  game_over;
    ypos_t ball_y;
    ypos_t paddleL_y;
    ypos_t paddleR_y;

    modport master (
        output btnL_up, btnL_dn, btnR_up, btnR_dn, ai_mode, game_over, ball_y,
        input  paddleL_y, paddleR_y
    );

    modport slave (
        input  btnL_up, btnL_dn, btnR_up, btnR_dn, ai_mode, game_over, ball_y,
        output paddleL_y, paddleR_y
    );

endinterface

// File: rtl/btn_debounce.sv
// Purpose: two-flop synchronizer plus debouncer for one raw push-button.
// Latency: 2 sync cycles + DB_CYCLES stable cycles before btn_db changes.
// Backpressure: none; free-running level filter.
module btn_debounce #(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing samples; flip only on an unbroken run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            btn_db <= 1'b0;
        end else if (sync2 == btn_db) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            cnt    <= '0;
            btn_db <= sync2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/paddle_control.sv
// Purpose: debounced button / tracking-AI paddle movement, clamped to screen.
// Latency: position updates on the tick edge; game_over recentres in 1 cycle.
// Backpressure: none; outputs are registered levels consumed every cycle.
module paddle_control
    import pong_pkg::*;
#(
    parameter int PADDLE_SPEED = 4,
    parameter int AI_SPEED     = 3,
    parameter int AI_DEADZONE  = 4,
    parameter int DIV_W        = 18,
    parameter int DB_CYCLES    = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    paddle_control_if.slave  bus
);

    logic             l_up;
    logic             l_dn;
    logic             r_up;
    logic             r_dn;
    logic             ai_s1;
    logic             ai_s2;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    ypos_t            pos_l;
    ypos_t            pos_r;
    ypos_t            next_l;
    ypos_t            next_r;
    ycalc_t           l_ext;
    ycalc_t           r_ext;
    ycalc_t           ball_c;
    ycalc_t           pad_c;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l_up (.clk(clk), .rst_n(rst_n), .btn_raw(bus.btnL_up), .btn_db(l_up));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l_dn (.clk(clk), .rst_n(rst_n), .btn_raw(bus.btnL_dn), .btn_db(l_dn));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r_up (.clk(clk), .rst_n(rst_n), .btn_raw(bus.btnR_up), .btn_db(r_up));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r_dn (.clk(clk), .rst_n(rst_n), .btn_raw(bus.btnR_dn), .btn_db(r_dn));

    // ai_mode is a slow level switch: synchronize only, no debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ai_s1 <= 1'b0;
            ai_s2 <= 1'b0;
        end else begin
            ai_s1 <= bus.ai_mode;
            ai_s2 <= ai_s1;
        end
    end

    // Free-running motion divider; wrapping to zero marks a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == '0);

    // Candidate next positions from buttons or the tracking AI, pre-clamped.
    always_comb begin
        l_ext  = ycalc_t'({2'b00, pos_l});
        r_ext  = ycalc_t'({2'b00, pos_r});
        ball_c = ycalc_t'({2'b00, bus.ball_y}) + ycalc_t'(BALL_SIZE / 2);
        pad_c  = r_ext + ycalc_t'(PADDLE_H / 2);
        next_l = pos_l;
        next_r = pos_r;
        if (l_up && !l_dn) begin
            next_l = clamp_y(l_ext - ycalc_t'(PADDLE_SPEED));
        end else if (l_dn && !l_up) begin
            next_l = clamp_y(l_ext + ycalc_t'(PADDLE_SPEED));
        end
        if (ai_s2) begin
            if (ball_c < pad_c - ycalc_t'(AI_DEADZONE)) begin
                next_r = clamp_y(r_ext - ycalc_t'(AI_SPEED));
            end else if (ball_c > pad_c + ycalc_t'(AI_DEADZONE)) begin
                next_r = clamp_y(r_ext + ycalc_t'(AI_SPEED));
            end
        end else if (r_up && !r_dn) begin
            next_r = clamp_y(r_ext - ycalc_t'(PADDLE_SPEED));
        end else if (r_dn && !r_up) begin
            next_r = clamp_y(r_ext + ycalc_t'(PADDLE_SPEED));
        end
    end

    // Position registers: game_over recentres every cycle, else move on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_l <= ypos_t'(PADDLE_Y_CENTER);
            pos_r <= ypos_t'(PADDLE_Y_CENTER);
        end else if (bus.game_over) begin
            pos_l <= ypos_t'(PADDLE_Y_CENTER);
            pos_r <= ypos_t'(PADDLE_Y_CENTER);
        end else if (tick) begin
            pos_l <= next_l;
            pos_r <= next_r;
        end
    end

    assign bus.paddleL_y = pos_l;
    assign bus.paddleR_y = pos_r;

endmodule

// File: tb/tb_paddle_control.sv
// Purpose: directed stimulus with a behavioural paddle model and literal checkpoints.
// Latency: model tracks 2-cycle sync, 3-cycle debounce, 16-cycle tick.
// Backpressure: n/a.
module tb_paddle_control;
    import pong_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    paddle_control_if bif ();

    paddle_control #(
        .DIV_W     (4),
        .DB_CYCLES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Positions as plain ints; each button keeps a history of raw samples so
    // the debounced level flips when the last three synchronized samples
    // (raw values seen 2..4 edges ago) all disagree with it.
    int       m_l   = 210;
    int       m_r   = 210;
    int       m_div = 0;
    bit       m_db[4] = '{default: 1'b0};
    bit [3:0] m_h[5]  = '{default: 4'b0};

    function automatic int lim(input int v);
        if (v < 0) return 0;
        if (v > 420) return 420;
        return v;
    endfunction

    function automatic int btn_move(input int y, input bit up, input bit dn);
        if (up && !dn) return lim(y - 4);
        if (dn && !up) return lim(y + 4);
        return y;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_l   = 210;
            m_r   = 210;
            m_div = 0;
            for (int b = 0; b < 4; b++) m_db[b] = 1'b0;
            for (int b = 0; b < 5; b++) m_h[b] = 4'b0;
        end else begin
            bit raw[5];
            bit tk;
            int bc;
            int pc;
            raw[0] = bif.btnL_up;
            raw[1] = bif.btnL_dn;
            raw[2] = bif.btnR_up;
            raw[3] = bif.btnR_dn;
            raw[4] = bif.ai_mode;
            tk    = (m_div == 0);
            m_div = (m_div + 1) % 16;
            if (bif.game_over) begin
                m_l = 210;
                m_r = 210;
            end else if (tk) begin
                m_l = btn_move(m_l, m_db[0], m_db[1]);
                if (m_h[4][1]) begin
                    bc = int'(bif.ball_y) + 5;
                    pc = m_r + 30;
                    if (bc < pc - 4) m_r = lim(m_r - 3);
                    else if (bc > pc + 4) m_r = lim(m_r + 3);
                end else begin
                    m_r = btn_move(m_r, m_db[2], m_db[3]);
                end
            end
            for (int b = 0; b < 4; b++) begin
                if (m_h[b][3:1] == {3{~m_db[b]}}) m_db[b] = ~m_db[b];
            end
            for (int b = 0; b < 5; b++) m_h[b] = {m_h[b][2:0], raw[b]};
        end
    end

    // Every-cycle comparison of both outputs against the model.
    always @(negedge clk) begin
        check("cmp_paddleL", int'(bif.paddleL_y), m_l);
        check("cmp_paddleR", int'(bif.paddleR_y), m_r);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input bit right, input int val, input int budget, input string name);
        int n = 0;
        while ((right ? int'(bif.paddleR_y) : int'(bif.paddleL_y)) != val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, right ? int'(bif.paddleR_y) : int'(bif.paddleL_y), val);
    endtask

    initial begin
        bif.btnL_up   = 1'b0;
        bif.btnL_dn   = 1'b0;
        bif.btnR_up   = 1'b0;
        bif.btnR_dn   = 1'b0;
        bif.ai_mode   = 1'b0;
        bif.game_over = 1'b0;
        bif.ball_y    = '0;
        #1 rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        check("reset_L", int'(bif.paddleL_y), 210);
        check("reset_R", int'(bif.paddleR_y), 210);

        // 1: 2-cycle glitch is rejected.
        bif.btnL_up = 1'b1;
        cyc(2);
        bif.btnL_up = 1'b0;
        cyc(64);
        check("glitch_L", int'(bif.paddleL_y), 210);

        // 2: left up, one step of 4 per 16 cycles, saturates at 0.
        bif.btnL_up = 1'b1;
        wait_until(1'b0, 206, 40, "left_first_step");
        cyc(16);
        check("left_step2", int'(bif.paddleL_y), 202);
        cyc(16);
        check("left_step3", int'(bif.paddleL_y), 198);
        wait_until(1'b0, 0, 1000, "left_reach_0");
        cyc(48);
        check("left_hold_0", int'(bif.paddleL_y), 0);
        bif.btnL_up = 1'b0;

        // 4: AI tracks ball centre 105, right down button ignored.
        bif.ball_y  = 10'd100;
        bif.ai_mode = 1'b1;
        bif.btnR_dn = 1'b1;
        wait_until(1'b1, 207, 60, "ai_first_step");
        wait_until(1'b1, 78, 900, "ai_reach_78");
        cyc(64);
        check("ai_hold_78", int'(bif.paddleR_y), 78);
        bif.btnR_dn = 1'b0;
        cyc(10);
        bif.ai_mode = 1'b0;
        cyc(40);
        check("ai_off_hold", int'(bif.paddleR_y), 78);

        // 3: both buttons hold; down alone saturates at 420.
        bif.btnR_up = 1'b1;
        bif.btnR_dn = 1'b1;
        cyc(64);
        check("both_hold", int'(bif.paddleR_y), 78);
        bif.btnR_up = 1'b0;
        wait_until(1'b1, 418, 1500, "right_reach_418");
        cyc(16);
        check("right_clamp_420", int'(bif.paddleR_y), 420);
        cyc(48);
        check("right_hold_420", int'(bif.paddleR_y), 420);

        // 5: game_over recentres in one cycle and freezes.
        bif.btnL_up   = 1'b1;
        bif.game_over = 1'b1;
        cyc(1);
        check("go_L_1cyc", int'(bif.paddleL_y), 210);
        check("go_R_1cyc", int'(bif.paddleR_y), 210);
        cyc(50);
        check("go_L_frozen", int'(bif.paddleL_y), 210);
        check("go_R_frozen", int'(bif.paddleR_y), 210);
        bif.game_over = 1'b0;
        wait_until(1'b0, 206, 20, "go_resume_L");
        check("go_resume_R", int'(bif.paddleR_y), 214);
        bif.btnL_up = 1'b0;
        bif.btnR_dn = 1'b0;
        cyc(8);

        // 6: asynchronous reset mid-move, then debounce must re-qualify.
        bif.btnL_dn = 1'b1;
        wait_until(1'b0, 214, 60, "pre_reset_move");
        cyc(3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_L", int'(bif.paddleL_y), 210);
        check("async_rst_R", int'(bif.paddleR_y), 210);
        cyc(2);
        rst_n = 1'b1;
        cyc(16);
        check("post_rst_hold", int'(bif.paddleL_y), 210);
        cyc(1);
        check("post_rst_move", int'(bif.paddleL_y), 214);
        bif.btnL_dn = 1'b0;
        cyc(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/paddle_control.md
# paddle_control

Generates the vertical positions of the left and right paddles consumed by the ball motion logic. Raw push-buttons are synchronized and debounced, then paddles move at a fixed rate on the shared motion tick. Travel is clamped to the screen. Optionally, the right paddle is driven by a simple tracking AI that follows `ball_y`.

## Interface
- `SCREEN_H`, 480: visible height in pixels.
- `PADDLE_H`, 60: paddle height in pixels.
- `BALL_SIZE`, 10: ball edge length, used for the AI target centre.
- `PADDLE_SPEED`, 4: pixels per tick under button control.
- `AI_SPEED`, 3: pixels per tick under AI control.
- `AI_DEADZONE`, 4: allowed centre error before the AI moves.
- `DIV_W`, 18: motion-tick divider width; tick period is 2^DIV_W cycles.
- `DB_CYCLES`, 50000: consecutive stable cycles required to accept a button change.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `btnL_up`, `btnL_dn`, in, 1 each: raw left buttons, active-high, asynchronous.
- `btnR_up`, `btnR_dn`, in, 1 each: raw right buttons, active-high, asynchronous.
- `ai_mode`, in, 1: asynchronous level; 1 = right paddle under AI control.
- `game_over`, in, 1: synchronous; freezes and recentres both paddles.
- `ball_y`, in, 10: ball top edge, synchronous.
- `paddleL_y`, out, 10: left paddle top edge, registered.
- `paddleR_y`, out, 10: right paddle top edge, registered.

## Operation
- Constants:
  - Y_MAX = SCREEN_H − PADDLE_H = 420.
  - Y_CENTER = Y_MAX/2 = 210.
- Each button input:
  - Two-flop synchronizer, then debouncer.
  - The debounced level flips only after the synchronized level has differed from it for DB_CYCLES consecutive cycles.
  - Any sample equal to the debounced level clears the counter.
- `ai_mode` input: two-flop synchronizer only.
- Divider:
  - Free-running DIV_W-bit counter, reset to 0.
  - `tick` = (counter == 0), so the first tick occurs on the first clock edge after reset release.
- Button move, evaluated per paddle, on tick only:
  - up only: y ← max(y − PADDLE_SPEED, 0).
  - down only: y ← min(y + PADDLE_SPEED, Y_MAX).
  - both or neither: hold.
- AI move, right paddle, on tick, only when synced `ai_mode` = 1:
  - ball centre bc = `ball_y` + BALL_SIZE/2; paddle centre pc = y + PADDLE_H/2.
  - bc < pc − AI_DEADZONE: move up by AI_SPEED, clamped at 0.
  - bc > pc + AI_DEADZONE: move down by AI_SPEED, clamped at Y_MAX.
  - otherwise: hold.
  - Right buttons are ignored while AI is active.
- Arithmetic:
  - All sums and differences are computed at 12-bit signed width before clamping.
  - No wrap-around is permitted; a result < 0 becomes 0, and a result > Y_MAX becomes Y_MAX.
- `game_over` = 1:
  - Both paddles are forced to Y_CENTER on every clock, independent of tick.
  - Buttons and AI are ignored.
  - Debouncers and divider keep running.
- `ai_mode` change: takes effect at the next tick after synchronization. No position jump.

## Timing
- Reset values:
  - `paddleL_y` = `paddleR_y` = 210.
  - Divider = 0.
  - Debounced levels = 0; debounce counters = 0; synchronizers = 0.
- Reset asserted mid-operation restores all of the above asynchronously.
- Button latency: 2 cycles of synchronization + DB_CYCLES cycles until the debounced level changes. Movement occurs at the next tick after that.
- Position registers update on the tick edge; the new value is visible from the following cycle.
- At most one move per paddle per tick.
- `game_over` effect: 1-cycle latency (registered).
- `game_over` deasserting: movement resumes at the next tick.

## Structure
- Shared package `pong_pkg`:
  - SCREEN_W, SCREEN_H, BALL_SIZE, PADDLE_W, PADDLE_H.
  - PADDLEL_X, PADDLER_X, derived PADDLE_Y_MAX and PADDLE_Y_CENTER.
  - Used by ball motion, renderer and this block.
- Sub-module `btn_debounce`: synchronizer plus debounce counter, parameter DB_CYCLES. Instantiated four times.
- Divider, move/clamp logic and AI logic live in the top module.

## Test plan
Bench parameters: DIV_W = 4, DB_CYCLES = 3.

1. Reset and glitch rejection:
   - Release reset → both outputs = 210.
   - Pulse `btnL_up` for 2 cycles → no movement after 64 cycles.
2. Left button movement:
   - Hold `btnL_up` → debounced level high after 5 cycles.
   - `paddleL_y` steps 210→206→202… one step per 16 cycles.
   - Saturates at 0 and stays there.
3. Down saturation and conflicting inputs:
   - Hold `btnR_dn` from 418 → 420, then holds at 420.
   - Both `btnR_up` and `btnR_dn` held → no change.
4. AI tracking:
   - `ai_mode` = 1, `ball_y` = 100, right paddle at 210: steps −3 per tick until the centre is within ±4 of ball centre 105.
   - Right buttons have no effect while AI is active.
5. Game over:
   - Paddles at 0 and 420; assert `game_over` → both = 210 one cycle later and stay there while buttons are held.
   - Deassert `game_over` → movement resumes at the next tick.
6. Reset mid-move:
   - Assert `rst_n` = 0 while the left paddle is moving → outputs = 210 immediately (asynchronously).
   - After release, debounce must be re-satisfied before any move.
